// File: rtl/packet_filter_pkg.sv
// Shared types and constants for the packet filter slice.
// The FIFO entry control flags are a packed struct; the payload fields are appended at the top level.
package packet_filter_pkg;

   localparam int unsigned CNT_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PASS,
      ST_DROP,
      ST_TRUNC
   } pf_state_t;

   typedef struct packed {
      logic sop;
      logic eop;
      logic err;
   } pf_ctrl_t;

   localparam int unsigned CTRL_W = $bits(pf_ctrl_t);

endpackage

// File: rtl/packet_filter_fifo.sv
// Synchronous FIFO with a registered free-entry count; guarded against overflow and underflow.
module packet_filter_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk_host,
   input  logic                     rst_n,
   input  logic                     i_wr_en,
   input  logic [WIDTH-1:0]         i_wr_data,
   input  logic                     i_rd_en,
   output logic [WIDTH-1:0]         o_rd_data,
   output logic                     o_empty,
   output logic                     o_full,
   output logic [$clog2(DEPTH):0]   o_free
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_free;
   logic             w_wr;
   logic             w_rd;

   assign o_free    = r_free;
   assign o_full    = (r_free == '0);
   assign o_empty   = (r_free == (AW+1)'(DEPTH));
   assign w_wr      = i_wr_en && !o_full;
   assign w_rd      = i_rd_en && !o_empty;
   assign o_rd_data = r_mem[r_rd_ptr];

   always_ff @(posedge clk_host) begin
      if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
   end

   always_ff @(posedge clk_host) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_free   <= (AW+1)'(DEPTH);
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_wr, w_rd})
            2'b10:   r_free <= r_free - 1'b1;
            2'b01:   r_free <= r_free + 1'b1;
            default: r_free <= r_free;
         endcase
      end
   end

endmodule

// File: rtl/packet_filter.sv
// Header-match packet filter feeding an output FIFO; truncates packets that overrun the FIFO.
// Packet counters are built only when PACKET_FILTER_STATS_EN is defined.
module packet_filter
   import packet_filter_pkg::*;
#(
   parameter int unsigned WIDTH_DATA_BYTES  = 8,
   parameter int unsigned WIDTH_HDR_A_BYTES = 6,
   parameter int unsigned WIDTH_HDR_B_BYTES = 4,
   parameter int unsigned FIFO_DEPTH        = 8
) (
   input  logic                            clk_host,
   input  logic                            rst_n,
   input  logic                            bus_in_valid,
   input  logic                            bus_in_sop,
   input  logic                            bus_in_eop,
   input  logic [WIDTH_DATA_BYTES-1:0]     bus_in_byteen,
   input  logic [8*WIDTH_DATA_BYTES-1:0]   bus_in_data,
   input  logic [8*WIDTH_HDR_A_BYTES-1:0]  headerA,
   input  logic [8*WIDTH_HDR_B_BYTES-1:0]  headerB,
   input  logic                            cfg_filter_en,
   input  logic [8*WIDTH_HDR_A_BYTES-1:0]  cfg_match_a,
   input  logic [8*WIDTH_HDR_A_BYTES-1:0]  cfg_mask_a,
   input  logic                            bus_out_ready,
   output logic                            bus_out_valid,
   output logic                            bus_out_sop,
   output logic                            bus_out_eop,
   output logic                            bus_out_err,
   output logic [WIDTH_DATA_BYTES-1:0]     bus_out_byteen,
   output logic [8*WIDTH_DATA_BYTES-1:0]   bus_out_data,
   output logic [8*WIDTH_HDR_B_BYTES-1:0]  bus_out_hdr_b,
   output logic [CNT_W-1:0]                stat_pass_cnt,
   output logic [CNT_W-1:0]                stat_drop_cnt,
   output logic [CNT_W-1:0]                stat_trunc_cnt
);

   localparam int unsigned DB = 8*WIDTH_DATA_BYTES;
   localparam int unsigned HB = 8*WIDTH_HDR_B_BYTES;
   localparam int unsigned EW = CTRL_W + WIDTH_DATA_BYTES + DB + HB;
   localparam int unsigned FW = $clog2(FIFO_DEPTH) + 1;

   pf_state_t        r_state, w_next;
   logic [HB-1:0]    r_hdr_b;
   logic             w_match;
   logic             w_wr_en, w_wr_eop, w_wr_err;
   logic             w_pass_inc, w_drop_inc, w_trunc_inc;
   pf_ctrl_t         w_wr_ctrl, w_rd_ctrl;
   logic [HB-1:0]    w_wr_hdr;
   logic [EW-1:0]    w_wr_data, w_rd_data;
   logic             w_empty, w_full;
   logic [FW-1:0]    w_free;

   assign w_match = !cfg_filter_en || (((headerA ^ cfg_match_a) & cfg_mask_a) == '0);

   always_ff @(posedge clk_host) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_hdr_b <= '0;
      end else begin
         r_state <= w_next;
         if (bus_in_valid && bus_in_sop) r_hdr_b <= headerB;
      end
   end

   // Any sop restarts admission regardless of state; free is the registered count, so a
   // same-cycle pop is deliberately not credited.
   always_comb begin
      w_next      = r_state;
      w_wr_en     = 1'b0;
      w_wr_eop    = bus_in_eop;
      w_wr_err    = 1'b0;
      w_pass_inc  = 1'b0;
      w_drop_inc  = 1'b0;
      w_trunc_inc = 1'b0;
      if (bus_in_valid) begin
         if (bus_in_sop) begin
            if (w_match && (w_free >= FW'(2))) begin
               w_wr_en    = 1'b1;
               w_pass_inc = 1'b1;
               w_next     = bus_in_eop ? ST_IDLE : ST_PASS;
            end else begin
               w_drop_inc = 1'b1;
               w_next     = bus_in_eop ? ST_IDLE : ST_DROP;
            end
         end else begin
            case (r_state)
               ST_PASS: begin
                  w_wr_en = !w_full;
                  if ((w_free == FW'(1)) && !bus_in_eop) begin
                     w_wr_eop    = 1'b1;
                     w_wr_err    = 1'b1;
                     w_trunc_inc = 1'b1;
                     w_next      = ST_TRUNC;
                  end else if (bus_in_eop) begin
                     w_next = ST_IDLE;
                  end
               end
               ST_DROP, ST_TRUNC: begin
                  if (bus_in_eop) w_next = ST_IDLE;
               end
               default: ;
            endcase
         end
      end
   end

   assign w_wr_ctrl = '{sop: bus_in_sop, eop: w_wr_eop, err: w_wr_err};
   assign w_wr_hdr  = bus_in_sop ? headerB : r_hdr_b;
   assign w_wr_data = {w_wr_ctrl, bus_in_byteen, bus_in_data, w_wr_hdr};

   packet_filter_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_host  (clk_host),
      .rst_n     (rst_n),
      .i_wr_en   (w_wr_en),
      .i_wr_data (w_wr_data),
      .i_rd_en   (bus_out_ready),
      .o_rd_data (w_rd_data),
      .o_empty   (w_empty),
      .o_full    (w_full),
      .o_free    (w_free)
   );

   assign w_rd_ctrl      = pf_ctrl_t'(w_rd_data[EW-1 -: CTRL_W]);
   assign bus_out_valid  = !w_empty;
   assign bus_out_sop    = bus_out_valid && w_rd_ctrl.sop;
   assign bus_out_eop    = bus_out_valid && w_rd_ctrl.eop;
   assign bus_out_err    = bus_out_valid && w_rd_ctrl.err;
   assign bus_out_byteen = bus_out_valid ? w_rd_data[HB+DB +: WIDTH_DATA_BYTES] : '0;
   assign bus_out_data   = bus_out_valid ? w_rd_data[HB +: DB] : '0;
   assign bus_out_hdr_b  = bus_out_valid ? w_rd_data[HB-1:0] : '0;

`ifdef PACKET_FILTER_STATS_EN
   logic [CNT_W-1:0] r_pass_cnt, r_drop_cnt, r_trunc_cnt;

   always_ff @(posedge clk_host) begin
      if (!rst_n) begin
         r_pass_cnt  <= '0;
         r_drop_cnt  <= '0;
         r_trunc_cnt <= '0;
      end else begin
         if (w_pass_inc  && (r_pass_cnt  != '1)) r_pass_cnt  <= r_pass_cnt  + 1'b1;
         if (w_drop_inc  && (r_drop_cnt  != '1)) r_drop_cnt  <= r_drop_cnt  + 1'b1;
         if (w_trunc_inc && (r_trunc_cnt != '1)) r_trunc_cnt <= r_trunc_cnt + 1'b1;
      end
   end

   assign stat_pass_cnt  = r_pass_cnt;
   assign stat_drop_cnt  = r_drop_cnt;
   assign stat_trunc_cnt = r_trunc_cnt;
`else
   logic w_unused_stats;
   assign w_unused_stats = w_pass_inc ^ w_drop_inc ^ w_trunc_inc;
   assign stat_pass_cnt  = '0;
   assign stat_drop_cnt  = '0;
   assign stat_trunc_cnt = '0;
`endif

endmodule
